// File: rtl/int_vector_ctrl.sv
// Vectored interrupt controller: edge-detected requests, pending, vector grant.
// Define INTC_RR_PRIORITY_EN for round-robin arbitration (fixed otherwise).
module int_vector_ctrl #(
  parameter int               N_CH     = 4,
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE = 16'hFDA9,
  parameter logic [ADDR_W-1:0] VEC_STEP = 16'h0256,
  localparam int              CH_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [N_CH-1:0]   i_irq,
  input  logic [ADDR_W-1:0] i_data_bus,
  input  logic [1:0]        i_cfg_op,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic              i_ack,
  input  logic              i_eoi,
  output logic [ADDR_W-1:0] o_addr_bus,
  output logic              o_addr_valid,
  output logic              o_pc_load,
  output logic              o_decoder_interrupt,
  output logic [N_CH-1:0]   o_in_service,
  output logic [N_CH-1:0]   o_pending
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   irq_q;
  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   en_q, en_d;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   insvc_q, insvc_d;
  logic [N_CH-1:0]   ack_clr;
  logic [N_CH-1:0]   elig;
  logic [ADDR_W-1:0] vec_q [N_CH];
  logic [ADDR_W-1:0] vec_d [N_CH];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   sel;
  logic              sel_vld;
  logic              pcl_q, pcl_d;
  logic              armed_q;

  function automatic logic [ADDR_W-1:0] def_vec(input int c);
    return VEC_BASE - ADDR_W'(c) * VEC_STEP;
  endfunction

  // armed_q blocks the first post-reset sample so held levels are not edges
  assign rise = i_irq & en_q & ~irq_q & {N_CH{armed_q}};
  assign elig = pend_q & en_q;
  assign pend_d = (pend_q & ~ack_clr) | rise;

`ifdef INTC_RR_PRIORITY_EN
  logic [CH_W-1:0] rr_q;

  // round-robin search starting at rr_q
  always_comb begin
    logic [CH_W-1:0] idx;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = rr_q;
    for (int i = 0; i < N_CH; i++) begin
      if (!sel_vld && elig[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
      idx = (idx == CH_W'(N_CH - 1)) ? '0 : idx + 1'b1;
    end
  end

  // pointer moves past the channel just accepted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_q <= '0;
    end else if (state_q == REQ && i_ack) begin
      rr_q <= (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
    end
  end
`else
  // fixed priority: lowest eligible index wins
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel     = CH_W'(i);
        sel_vld = 1'b1;
      end
    end
  end
`endif

  // configuration write decode
  always_comb begin
    vec_d = vec_q;
    en_d  = en_q;
    unique case (1'b1)
      (i_cfg_op == 2'b01): vec_d[i_cfg_ch] = i_data_bus;
      (i_cfg_op == 2'b10): en_d = i_data_bus[N_CH-1:0];
      (i_cfg_op == 2'b11): begin
        for (int c = 0; c < N_CH; c++) vec_d[c] = def_vec(c);
        en_d = '1;
      end
      default: ;
    endcase
  end

  // FSM next state: grant latch, ack pulse, in-service tracking
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    insvc_d = insvc_q;
    pcl_d   = 1'b0;
    ack_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = REQ;
          grant_d = sel;
          addr_d  = vec_q[sel];
        end
      end
      REQ: begin
        if (i_ack) begin
          state_d = SERVICE;
          pcl_d   = 1'b1;
          insvc_d = N_CH'(1) << grant_q;
          ack_clr = N_CH'(1) << grant_q;
        end
      end
      SERVICE: begin
        if (i_eoi) begin
          state_d = IDLE;
          insvc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and grant registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      insvc_q <= '0;
      pcl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      insvc_q <= insvc_d;
      pcl_q   <= pcl_d;
    end
  end

  // request sampling, pending and configuration registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_q   <= '0;
      pend_q  <= '0;
      en_q    <= '1;
      armed_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) vec_q[c] <= def_vec(c);
    end else begin
      irq_q   <= i_irq & en_q;
      pend_q  <= pend_d;
      en_q    <= en_d;
      armed_q <= 1'b1;
      vec_q   <= vec_d;
    end
  end

  assign o_addr_valid        = (state_q == REQ);
  assign o_addr_bus          = o_addr_valid ? addr_q : '0;
  assign o_pc_load           = pcl_q;
  assign o_decoder_interrupt = (state_q == SERVICE);
  assign o_in_service        = insvc_q;
  assign o_pending           = pend_q;

endmodule

// File: tb/tb_int_vector_ctrl.sv
// Scoreboard bench for int_vector_ctrl.
// Expected vectors are queued at stimulus time and popped at grant.
module tb_int_vector_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  i_irq = '0;
  logic [15:0] i_data_bus = '0;
  logic [1:0]  i_cfg_op = '0;
  logic [1:0]  i_cfg_ch = '0;
  logic        i_ack = 1'b0;
  logic        i_eoi = 1'b0;
  logic [15:0] o_addr_bus;
  logic        o_addr_valid;
  logic        o_pc_load;
  logic        o_decoder_interrupt;
  logic [3:0]  o_in_service;
  logic [3:0]  o_pending;

  typedef struct {
    int          ch;
    logic [15:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_ch  = 0;

  int_vector_ctrl dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .i_irq               (i_irq),
    .i_data_bus          (i_data_bus),
    .i_cfg_op            (i_cfg_op),
    .i_cfg_ch            (i_cfg_ch),
    .i_ack               (i_ack),
    .i_eoi               (i_eoi),
    .o_addr_bus          (o_addr_bus),
    .o_addr_valid        (o_addr_valid),
    .o_pc_load           (o_pc_load),
    .o_decoder_interrupt (o_decoder_interrupt),
    .o_in_service        (o_in_service),
    .o_pending           (o_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [15:0] v);
    exp_t e;
    e.ch  = ch;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic cfg(input logic [1:0] op, input logic [1:0] ch,
                     input logic [15:0] d);
    i_cfg_op   = op;
    i_cfg_ch   = ch;
    i_data_bus = d;
    tick();
    i_cfg_op   = 2'b00;
  endtask

  task automatic wait_grant();
    int   n;
    exp_t e;
    n = 0;
    while (!o_addr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", 32'(o_addr_valid), 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("vector", 32'(o_addr_bus), 32'(e.vec));
      cur_ch = e.ch;
    end
  endtask

  task automatic serve();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk("pc_load", 32'(o_pc_load), 1);
    chk("in_service", 32'(o_in_service), 32'(1) << cur_ch);
    chk("dec_int", 32'(o_decoder_interrupt), 1);
    chk("valid_off", 32'(o_addr_valid), 0);
    tick();
    chk("pc_load_1cyc", 32'(o_pc_load), 0);
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;
    chk("eoi_insvc", 32'(o_in_service), 0);
    chk("eoi_dec", 32'(o_decoder_interrupt), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(o_addr_bus), 0);
    chk({tag, "_valid"}, 32'(o_addr_valid), 0);
    chk({tag, "_pcl"}, 32'(o_pc_load), 0);
    chk({tag, "_dec"}, 32'(o_decoder_interrupt), 0);
    chk({tag, "_insvc"}, 32'(o_in_service), 0);
    chk({tag, "_pend"}, 32'(o_pending), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    n_rst = 1'b1;
    tick();
    tick();

    // single request on channel 1
    i_irq = 4'b0010;
    push(1, 16'hFB53);
    tick();
    chk("lat_pend", 32'(o_pending), 4'b0010);
    chk("lat_valid0", 32'(o_addr_valid), 0);
    tick();
    chk("lat_valid1", 32'(o_addr_valid), 1);
    wait_grant();
    serve();
    chk("pend_clr", 32'(o_pending), 0);
    i_irq = 4'b0000;
    tick();

    // simultaneous requests on 0 and 3
    i_irq = 4'b1001;
`ifdef INTC_RR_PRIORITY_EN
    push(3, 16'hF6A7);
    push(0, 16'hFDA9);
`else
    push(0, 16'hFDA9);
    push(3, 16'hF6A7);
`endif
    tick();
    chk("both_pend", 32'(o_pending), 4'b1001);
    wait_grant();
    serve();
    wait_grant();
    serve();
    i_irq = 4'b0000;
    tick();

    // reprogram channel 2 and mask it
    cfg(2'b01, 2'd2, 16'h1234);
    cfg(2'b10, 2'd0, 16'h000B);
    i_irq = 4'b0100;
    tick();
    tick();
    tick();
    chk("masked_pend", 32'(o_pending), 0);
    chk("masked_valid", 32'(o_addr_valid), 0);
    i_irq = 4'b0000;
    tick();
    cfg(2'b10, 2'd0, 16'h000F);
    i_irq = 4'b0100;
    push(2, 16'h1234);
    wait_grant();
    serve();
    i_irq = 4'b0000;
    tick();

    // ack outside REQ is ignored
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk("stray_ack_pcl", 32'(o_pc_load), 0);
    chk("stray_ack_svc", 32'(o_in_service), 0);

    // restore defaults while a reprogrammed vector is offered
    i_irq = 4'b0100;
    push(2, 16'h1234);
    wait_grant();
    cfg(2'b11, 2'd0, 16'h0000);
    chk("hold_addr", 32'(o_addr_bus), 16'h1234);
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;
    chk("stray_eoi", 32'(o_addr_valid), 1);
    chk("hold_addr2", 32'(o_addr_bus), 16'h1234);
    serve();
    i_irq = 4'b0000;
    tick();
    i_irq = 4'b0100;
    push(2, 16'hF8FD);
    wait_grant();
    serve();
    i_irq = 4'b0000;
    tick();

    // reset while in service
    i_irq = 4'b0010;
    push(1, 16'hFB53);
    wait_grant();
    i_irq = 4'b0001;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    chk("svc_pend", 32'(o_pending), 4'b0001);
    chk("no_nest", 32'(o_addr_valid), 0);
    chk("svc_dec", 32'(o_decoder_interrupt), 1);
    n_rst = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    tick();
    chk_zero("midrst_hold");
    n_rst = 1'b1;
    tick();
    tick();
    tick();
    chk("held_lvl_pend", 32'(o_pending), 0);
    chk("held_lvl_valid", 32'(o_addr_valid), 0);
    i_irq = 4'b0000;
    tick();
    i_irq = 4'b0001;
    push(0, 16'hFDA9);
    wait_grant();
    serve();
    i_irq = 4'b0000;
    tick();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
